// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state encodings and a counter-width helper.
package arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // A one-bit operand still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: difference and borrow-out of a - b.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor, LSB first, one bit per clock.
// Two half subtractors plus a borrow flop form the full-subtract cell.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         borrow
);

   localparam int CW = cnt_width(N);

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  sa;
   logic [N-1:0]  sb;
   logic [N-1:0]  res;
   logic [N-1:0]  res_next;
   logic [CW-1:0] cnt;
   logic          bw;
   logic          bw_next;
   logic          armed;
   logic          accept;
   logic          last_bit;
   logic          d_ab;
   logic          b_ab;
   logic          bit_d;
   logic          b_bw;

   half_subtractor hs_ab (
      .a    (sa[0]),
      .b    (sb[0]),
      .d    (d_ab),
      .bout (b_ab)
   );

   half_subtractor hs_bw (
      .a    (d_ab),
      .b    (bw),
      .d    (bit_d),
      .bout (b_bw)
   );

   assign bw_next  = b_ab | b_bw;
   assign last_bit = (cnt == CW'(N - 1));
   // armed stays low for the first edge after reset release.
   assign accept   = (state == IDLE) && start && armed;

   always_comb begin
      res_next        = res >> 1;
      res_next[N-1]   = bit_d;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)   state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed  <= 1'b0;
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         cnt    <= '0;
         bw     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         armed <= 1'b1;
         done  <= (state == RUN) && last_bit;
         if (accept) begin
            sa   <= a;
            sb   <= b;
            res  <= '0;
            cnt  <= '0;
            bw   <= 1'b0;
            busy <= 1'b1;
         end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= res_next;
            bw  <= bw_next;
            cnt <= cnt + CW'(1);
            // Results are published only on the transition into DONE.
            if (last_bit) begin
               diff   <= res_next;
               borrow <= bw_next;
            end
         end else if (state == DONE) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=8 and N=1 instances)
// against an arithmetic reference model.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       borrow1;

   int n_checks = 0;
   int n_fail   = 0;

   serial_subtractor #(.N(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   serial_subtractor #(.N(1)) dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start1),
      .a      (a1),
      .b      (b1),
      .busy   (busy1),
      .done   (done1),
      .diff   (diff1),
      .borrow (borrow1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: unsigned subtraction modulo 2^8.
   function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] d;
      d = 8'((int'(x) - int'(y) + 256) % 256);
      return {(x < y) ? 1'b1 : 1'b0, d};
   endfunction

   // Drives one operation on the N=8 instance; returns what it observed.
   // lat counts edges after the accepting edge until done is seen (-1: timeout).
   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                        output int lat, output logic busy_acc,
                        output logic [7:0] od, output logic ob);
      a     = ia;
      b     = ib;
      start = 1'b1;
      step();
      start    = 1'b0;
      busy_acc = busy;
      a        = 8'($urandom);
      b        = 8'($urandom);
      lat      = -1;
      od       = 8'h00;
      ob       = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            lat = k;
            od  = diff;
            ob  = borrow;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      a = 8'h00; b = 8'h00; a1 = 1'b0; b1 = 1'b0;
      #2;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++;
      if (diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", diff); end
      n_checks++;
      if (borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b want 0", borrow); end
      n_checks++;
      if ({busy1, done1, diff1, borrow1} !== 4'b0000)
         begin n_fail++; $display("FAIL reset_n1 got %b want 0000", {busy1, done1, diff1, borrow1}); end
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
   endtask

   task automatic test_basic();
      logic [7:0] va [4] = '{8'd200, 8'd55, 8'h5A, 8'h00};
      logic [7:0] vb [4] = '{8'd55, 8'd200, 8'h5A, 8'h01};
      int lat;
      logic bacc;
      logic [7:0] od;
      logic ob;
      logic [8:0] exp;
      for (int i = 0; i < 4; i++) begin
         exp = model8(va[i], vb[i]);
         do_op(va[i], vb[i], lat, bacc, od, ob);
         n_checks++;
         if (bacc !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0d] got %b want 1", i, bacc); end
         n_checks++;
         if (lat != 8) begin n_fail++; $display("FAIL basic_latency[%0d] got %0d want 8", i, lat); end
         n_checks++;
         if (od !== exp[7:0]) begin n_fail++; $display("FAIL basic_diff[%0d] got %h want %h", i, od, exp[7:0]); end
         n_checks++;
         if (ob !== exp[8]) begin n_fail++; $display("FAIL basic_borrow[%0d] got %b want %b", i, ob, exp[8]); end
         step();
         n_checks++;
         if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after[%0d] got done/busy %b want 00", i, {done, busy}); end
         n_checks++;
         if (diff !== exp[7:0]) begin n_fail++; $display("FAIL basic_hold[%0d] got %h want %h", i, diff, exp[7:0]); end
      end
   endtask

   task automatic test_random();
      int lat;
      logic bacc;
      logic [7:0] ra, rb, od;
      logic ob;
      logic [8:0] exp;
      int errs = 0;
      for (int i = 0; i < 25; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         exp = model8(ra, rb);
         do_op(ra, rb, lat, bacc, od, ob);
         if (lat != 8 || od !== exp[7:0] || ob !== exp[8]) begin
            errs++;
            $display("  random op a=%h b=%h: lat=%0d diff=%h borrow=%b expected diff=%h borrow=%b",
                     ra, rb, lat, od, ob, exp[7:0], exp[8]);
         end
         step();
      end
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL random_ops got %0d bad results want 0", errs); end
   endtask

   task automatic test_back_to_back();
      int pulses[$];
      int unstable = 0;
      int bad_gap  = 0;
      a     = 8'd10;
      b     = 8'd3;
      start = 1'b1;
      for (int k = 0; k < 45; k++) begin
         step();
         if (done) pulses.push_back(k);
         if (pulses.size() > 0 && diff !== 8'd7) unstable++;
      end
      start = 1'b0;
      step();
      step();
      n_checks++;
      if (pulses.size() != 4) begin n_fail++; $display("FAIL b2b_pulses got %0d want 4", pulses.size()); end
      n_checks++;
      if (pulses.size() == 0 || pulses[0] != 8)
         begin n_fail++; $display("FAIL b2b_first got %0d want 8", (pulses.size() == 0) ? -1 : pulses[0]); end
      for (int i = 1; i < pulses.size(); i++)
         if (pulses[i] - pulses[i-1] != 10) bad_gap++;
      n_checks++;
      if (bad_gap != 0) begin n_fail++; $display("FAIL b2b_spacing got %0d bad gaps want 0", bad_gap); end
      n_checks++;
      if (unstable != 0) begin n_fail++; $display("FAIL b2b_diff_stable got %0d bad cycles want 0", unstable); end
   endtask

   task automatic test_reset_mid_run();
      int seen = 0;
      int lat;
      logic bacc;
      logic [7:0] od;
      logic ob;
      a     = 8'hC3;
      b     = 8'h11;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL midrst_ctrl got busy/done %b want 00", {busy, done}); end
      n_checks++;
      if ({diff, borrow} !== 9'h000) begin n_fail++; $display("FAIL midrst_data got %h want 000", {diff, borrow}); end
      step();
      // Release with start already high: the first edge must not accept it.
      rst_n = 1'b1;
      a     = 8'd1;
      b     = 8'd2;
      start = 1'b1;
      step();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_first_edge got busy %b want 0", busy); end
      start = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (done) seen++;
         step();
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
      do_op(8'd1, 8'd2, lat, bacc, od, ob);
      n_checks++;
      if (lat != 8 || od !== 8'hFF || ob !== 1'b1)
         begin n_fail++; $display("FAIL midrst_next got lat=%0d diff=%h borrow=%b want 8/ff/1", lat, od, ob); end
      step();
   endtask

   task automatic test_n1();
      int lat;
      logic bacc;
      for (int i = 0; i < 4; i++) begin
         a1     = 1'(i >> 1);
         b1     = 1'(i);
         start1 = 1'b1;
         step();
         start1 = 1'b0;
         bacc   = busy1;
         lat    = -1;
         for (int k = 0; k < 10; k++) begin
            if (done1) begin lat = k; break; end
            step();
         end
         n_checks++;
         if (bacc !== 1'b1) begin n_fail++; $display("FAIL n1_busy[%0d] got %b want 1", i, bacc); end
         n_checks++;
         if (lat != 1) begin n_fail++; $display("FAIL n1_latency[%0d] got %0d want 1", i, lat); end
         n_checks++;
         if (diff1 !== 1'((i >> 1) - i)) begin n_fail++; $display("FAIL n1_diff[%0d] got %b want %b", i, diff1, 1'((i >> 1) - i)); end
         n_checks++;
         if (borrow1 !== ((i >> 1) < (i & 1))) begin n_fail++; $display("FAIL n1_borrow[%0d] got %b want %b", i, borrow1, ((i >> 1) < (i & 1))); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      test_n1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
